input_loader: RTL and testbench

INPUT_LOADER -- requirements
Module: input_loader

---
 rtl/input_loader_pkg.sv | 14 +
 rtl/input_loader_byte_slot_writer.sv | 21 ++
 rtl/input_loader.sv | 127 ++++++++++++
 tb/tb_input_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/input_loader_pkg.sv
// Shared definitions for the input loader: frame geometry and loader state encoding.
package input_loader_pkg;

  localparam int FILTER_BYTES = 9;
  localparam int DATA_BYTES   = 16;
  localparam int IDX_W        = 4;

  typedef enum logic [1:0] {
    LOAD_F = 2'b00,
    LOAD_D = 2'b01,
    WAIT   = 2'b10
  } state_t;

endpackage

// File: rtl/input_loader_byte_slot_writer.sv
// Decodes the current beat into a one-hot write enable for the filter or data assembly slots.
module byte_slot_writer
  import input_loader_pkg::*;
(
  input  logic                    beat,
  input  logic                    is_data,
  input  logic [IDX_W-1:0]        idx,
  output logic [FILTER_BYTES-1:0] filter_en,
  output logic [DATA_BYTES-1:0]   data_en
);

  always_comb begin
    filter_en = '0;
    data_en   = '0;
    for (int k = 0; k < FILTER_BYTES; k++)
      filter_en[k] = beat && !is_data && (idx == IDX_W'(k));
    for (int k = 0; k < DATA_BYTES; k++)
      data_en[k] = beat && is_data && (idx == IDX_W'(k));
  end

endmodule

// File: rtl/input_loader.sv
// Collects a 25-byte stream into a 3x3 filter and 4x4 image, then publishes the
// complete frame into a single output slot handshaked by frame_ack.
module input_loader
  import input_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [7:0]                in_byte,
  output logic                      in_ready,
  input  logic                      frame_ack,
  output logic                      frame_valid,
  output logic [8*DATA_BYTES-1:0]   DATA,
  output logic [8*FILTER_BYTES-1:0] FILTER,
  output logic [7:0]                frame_cnt
);

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic                      beat, publish;
  logic [FILTER_BYTES-1:0]   filter_en;
  logic [DATA_BYTES-1:0]     data_en;
  logic [8*FILTER_BYTES-1:0] asm_filter, asm_filter_nxt;
  logic [8*DATA_BYTES-1:0]   asm_data, asm_data_nxt;

  assign in_ready = (state != WAIT);
  assign beat     = in_valid && in_ready;

  byte_slot_writer u_writer (
    .beat      (beat),
    .is_data   (state == LOAD_D),
    .idx       (idx),
    .filter_en (filter_en),
    .data_en   (data_en)
  );

  // Next assembly includes the byte landing this edge so a publish can copy it directly.
  always_comb begin
    asm_filter_nxt = asm_filter;
    asm_data_nxt   = asm_data;
    for (int k = 0; k < FILTER_BYTES; k++)
      if (filter_en[k]) asm_filter_nxt[8*k +: 8] = in_byte;
    for (int k = 0; k < DATA_BYTES; k++)
      if (data_en[k]) asm_data_nxt[8*k +: 8] = in_byte;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    publish   = 1'b0;
    case (state)
      LOAD_F: begin
        if (beat) begin
          if (idx == IDX_W'(FILTER_BYTES - 1)) begin
            state_nxt = LOAD_D;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      LOAD_D: begin
        if (beat) begin
          if (idx == IDX_W'(DATA_BYTES - 1)) begin
            idx_nxt = '0;
            if (!frame_valid || frame_ack) begin
              publish   = 1'b1;
              state_nxt = LOAD_F;
            end else begin
              state_nxt = WAIT;
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      WAIT: begin
        if (frame_ack) begin
          publish   = 1'b1;
          state_nxt = LOAD_F;
        end
      end
      default: begin
        state_nxt = LOAD_F;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD_F;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_filter <= '0;
      asm_data   <= '0;
    end else begin
      asm_filter <= asm_filter_nxt;
      asm_data   <= asm_data_nxt;
    end
  end

  // An ack without a same-edge publish empties the slot; a publish always refills it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DATA        <= '0;
      FILTER      <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else if (publish) begin
      DATA        <= asm_data_nxt;
      FILTER      <= asm_filter_nxt;
      frame_valid <= 1'b1;
      frame_cnt   <= frame_cnt + 8'd1;
    end else if (frame_ack) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_loader.sv
// Directed bench for input_loader: single frames, held slot / WAIT, same-edge ack,
// mid-frame reset and a 256-frame run with random gaps against a byte-pattern model.
module tb_input_loader;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         in_ready;
  logic         frame_ack;
  logic         frame_valid;
  logic [127:0] DATA;
  logic [71:0]  FILTER;
  logic [7:0]   frame_cnt;

  int vecCount  = 0;
  int missCount = 0;

  input_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .frame_ack   (frame_ack),
    .frame_valid (frame_valid),
    .DATA        (DATA),
    .FILTER      (FILTER),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Frame whose beat k carries base+k: filter byte k = base+k, data byte k = base+9+k.
  function automatic logic [71:0] expFilter(input logic [7:0] base);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  function automatic logic [127:0] expData(input logic [7:0] base);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = base + 8'(9 + k);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    frame_ack = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One beat: waits (bounded) for in_ready, then lets one edge accept the byte.
  task automatic applyStimulus(input logic [7:0] b, input logic ack);
    int n;
    in_valid  = 1'b1;
    in_byte   = b;
    frame_ack = ack;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) checkOutput("readyTimeout", 128'(in_ready), 128'd1);
    tick();
    in_valid  = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] base, input int nBeats, input logic ackLast, input int gapMax);
    for (int k = 0; k < nBeats; k++) begin
      if (gapMax > 0) idle($urandom_range(0, gapMax));
      applyStimulus(base + 8'(k), (k == 24) ? ackLast : 1'b0);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    #1;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    frame_ack = 1'b0;
    idle(3);
    checkOutput("rstValid", 128'(frame_valid), 128'd0);
    checkOutput("rstData", DATA, 128'd0);
    checkOutput("rstFilter", 128'(FILTER), 128'd0);
    checkOutput("rstCnt", 128'(frame_cnt), 128'd0);
    rst = 1'b1;
    checkOutput("rstReady", 128'(in_ready), 128'd1);

    $display("[TB] single frame, bytes 1..25");
    sendFrame(8'd1, 24, 1'b0, 0);
    checkOutput("f1ValidEarly", 128'(frame_valid), 128'd0);
    applyStimulus(8'd25, 1'b0);
    checkOutput("f1Valid", 128'(frame_valid), 128'd1);
    checkOutput("f1Filter", 128'(FILTER), 128'(expFilter(8'd1)));
    checkOutput("f1Data", DATA, expData(8'd1));
    checkOutput("f1Cnt", 128'(frame_cnt), 128'd1);

    $display("[TB] second frame against a held slot");
    sendFrame(8'd101, 25, 1'b0, 0);
    checkOutput("f2WaitReady", 128'(in_ready), 128'd0);
    checkOutput("f2WaitData", DATA, expData(8'd1));
    checkOutput("f2WaitCnt", 128'(frame_cnt), 128'd1);
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    idle(3);
    checkOutput("f2HoldFilter", 128'(FILTER), 128'(expFilter(8'd1)));
    checkOutput("f2HoldValid", 128'(frame_valid), 128'd1);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    checkOutput("f2Valid", 128'(frame_valid), 128'd1);
    checkOutput("f2Data", DATA, expData(8'd101));
    checkOutput("f2Filter", 128'(FILTER), 128'(expFilter(8'd101)));
    checkOutput("f2Cnt", 128'(frame_cnt), 128'd2);
    checkOutput("f2Ready", 128'(in_ready), 128'd1);

    $display("[TB] ack on the same edge as the last beat");
    sendFrame(8'd201, 25, 1'b1, 0);
    checkOutput("f3Valid", 128'(frame_valid), 128'd1);
    checkOutput("f3Ready", 128'(in_ready), 128'd1);
    checkOutput("f3Data", DATA, expData(8'd201));
    checkOutput("f3Cnt", 128'(frame_cnt), 128'd3);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    checkOutput("ackClearValid", 128'(frame_valid), 128'd0);
    checkOutput("ackClearData", DATA, expData(8'd201));
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    checkOutput("ackIdleCnt", 128'(frame_cnt), 128'd3);
    checkOutput("ackIdleValid", 128'(frame_valid), 128'd0);

    $display("[TB] reset after 12 beats");
    sendFrame(8'd50, 12, 1'b0, 0);
    rst = 1'b0;
    #1;
    checkOutput("midRstData", DATA, 128'd0);
    checkOutput("midRstFilter", 128'(FILTER), 128'd0);
    checkOutput("midRstCnt", 128'(frame_cnt), 128'd0);
    tick();
    rst = 1'b1;
    sendFrame(8'd150, 25, 1'b0, 0);
    checkOutput("postRstFilter", 128'(FILTER), 128'(expFilter(8'd150)));
    checkOutput("postRstData", DATA, expData(8'd150));
    checkOutput("postRstCnt", 128'(frame_cnt), 128'd1);

    $display("[TB] 256 acked frames with random gaps");
    pulseReset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] base;
      base = 8'($urandom_range(0, 255));
      sendFrame(base, 25, 1'b0, 2);
      checkOutput("runValid", 128'(frame_valid), 128'd1);
      checkOutput("runFilter", 128'(FILTER), 128'(expFilter(base)));
      checkOutput("runData", DATA, expData(base));
      checkOutput("runCnt", 128'(frame_cnt), 128'((i + 1) % 256));
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
    end
    checkOutput("wrapCnt", 128'(frame_cnt), 128'd0);
    checkOutput("wrapValid", 128'(frame_valid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
